// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one external combinational 8x8 multiplier
// among four requesters. Two-stage pipeline: S1 holds the granted operand
// pair and drives the multiplier, S2 registers the product as the response.
module mult_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_x,
    input  logic [8*NREQ-1:0]    req_y,
    output logic [7:0]           mul_x,
    output logic [7:0]           mul_y,
    input  logic [15:0]          mul_z,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_z,
    output logic [1:0]           rsp_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    logic [1:0]       ptr_reg;
    logic             s1_valid_reg;
    logic [7:0]       s1_x_reg;
    logic [7:0]       s1_y_reg;
    logic [1:0]       s1_id_reg;
    logic             rsp_valid_reg;
    logic [15:0]      rsp_z_reg;
    logic [1:0]       rsp_id_reg;
    logic [CNT_W-1:0] op_count_reg;

    logic             s2_accept;
    logic             s1_accept;
    logic [NREQ-1:0]  rot_valid;
    logic [1:0]       offset;
    logic             found;
    logic [1:0]       winner;
    logic             grant_any;
    logic             rsp_xfer;
    logic [7:0]       win_x;
    logic [7:0]       win_y;

    // S2 frees up when empty or being consumed; S1 frees up when empty or advancing.
    assign s2_accept = !rsp_valid_reg || rsp_ready;
    assign s1_accept = !s1_valid_reg || s2_accept;
    assign rsp_xfer  = rsp_valid_reg && rsp_ready;

    // Rotate the request vector so position 0 is the requester at ptr.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            assign rot_valid[gi] = req_valid[ptr_reg + 2'(gi)];
        end
    endgenerate

    // First valid entry in the rotated vector wins.
    always_comb begin
        offset = 2'd0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot_valid[k]) begin
                offset = 2'(k);
                found  = 1'b1;
            end
        end
    end

    assign winner    = ptr_reg + offset;
    // Reset is asynchronous, so the grant is also masked combinationally.
    assign grant_any = found && s1_accept && !rst;
    assign win_x     = req_x[{winner, 3'b000} +: 8];
    assign win_y     = req_y[{winner, 3'b000} +: 8];

    // One-hot ready toward the winning requester only.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_any && (winner == 2'(gi));
        end
    endgenerate

    // Round-robin pointer moves past the winner on every accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 2'd0;
        end else if (grant_any) begin
            ptr_reg <= winner + 2'd1;
        end
    end

    // S1: capture the granted operands, or empty out once drained into S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_x_reg     <= 8'd0;
            s1_y_reg     <= 8'd0;
            s1_id_reg    <= 2'd0;
        end else if (grant_any) begin
            s1_valid_reg <= 1'b1;
            s1_x_reg     <= win_x;
            s1_y_reg     <= win_y;
            s1_id_reg    <= winner;
        end else if (s2_accept) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // S2: register the multiplier product, or clear once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_z_reg     <= 16'd0;
            rsp_id_reg    <= 2'd0;
        end else if (s1_valid_reg && s2_accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_z_reg     <= mul_z;
            rsp_id_reg    <= s1_id_reg;
        end else if (rsp_xfer) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_reg <= '0;
        end else if (rsp_xfer) begin
            op_count_reg <= op_count_reg + CNT_W'(1);
        end
    end

    assign mul_x     = s1_valid_reg ? s1_x_reg : 8'd0;
    assign mul_y     = s1_valid_reg ? s1_y_reg : 8'd0;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_z     = rsp_z_reg;
    assign rsp_id    = rsp_id_reg;
    assign busy      = s1_valid_reg | rsp_valid_reg;
    assign op_count  = op_count_reg;

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters; only the value 4 is supported.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the completed-operation counter.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, with asynchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 4 bits: bit i means requester i presents an operand pair.
REQ-006 The block SHALL have port req_ready, output, 4 bits: bit i means requester i is accepted this cycle.
REQ-007 The block SHALL have port req_x, input, 32 bits: the x operand for requester i on bits [8i+7:8i].
REQ-008 The block SHALL have port req_y, input, 32 bits: the y operand for requester i on bits [8i+7:8i].
REQ-009 The block SHALL have port mul_x, output, 8 bits: the x operand driven to the external combinational 8x8 unsigned multiplier.
REQ-010 The block SHALL have port mul_y, output, 8 bits: the y operand driven to the external multiplier.
REQ-011 The block SHALL have port mul_z, input, 16 bits: the external multiplier product, valid in the same cycle as mul_x and mul_y.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: a result is held on rsp_z and rsp_id.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-014 The block SHALL have port rsp_z, output, 16 bits: the registered product.
REQ-015 The block SHALL have port rsp_id, output, 2 bits: the index of the requester that owns rsp_z.
REQ-016 The block SHALL have port busy, output, 1 bit: stage S1 or stage S2 holds a valid entry.
REQ-017 The block SHALL have port op_count, output, CNT_W bits: the number of completed responses.

Function
REQ-018 A transfer SHALL occur on a rising edge where req_valid[i] & req_ready[i]; a response transfer SHALL occur where rsp_valid & rsp_ready.
REQ-019 At most one req_ready bit SHALL be high per cycle, and req_ready[i] SHALL be high only if req_valid[i] is high, requester i wins arbitration, and S1 can accept.
REQ-020 S1 can accept when S1 is empty or S2 can accept; S2 can accept when rsp_valid is 0 or rsp_ready is 1.
REQ-021 Arbitration SHALL be round-robin: the search starts at pointer ptr and runs ptr, ptr+1, ... modulo 4, and the first valid requester wins.
REQ-022 On each request transfer, ptr SHALL become the winner index + 1 modulo 4; ptr SHALL be unchanged otherwise, including when a valid request is stalled.
REQ-023 On a request transfer, S1 SHALL capture x, y and the winner id, and set s1_valid.
REQ-024 mul_x and mul_y SHALL be driven only from the S1 registers, and SHALL be 0 when S1 is empty.
REQ-025 When S1 is valid and S2 can accept, S2 SHALL capture mul_z into rsp_z and the S1 id into rsp_id, and set rsp_valid.
REQ-026 Latency SHALL be fixed: for a request transfer at edge E, rsp_valid SHALL rise after edge E+1 when the path is unstalled.
REQ-027 Throughput SHALL be 1 operation per cycle while rsp_ready stays high.
REQ-028 Backpressure: while rsp_valid & !rsp_ready, rsp_z and rsp_id SHALL hold, S1 SHALL hold, and no request SHALL be accepted if S1 is full.
REQ-029 Simultaneous events: in a single edge, a response transfer, an S1-to-S2 advance and a new request transfer SHALL all occur with no bubble.
REQ-030 When S1 is not advancing and no new request transfers, s1_valid SHALL clear if S1 drained into S2; rsp_valid SHALL clear on a response transfer with no new S2 capture.
REQ-031 op_count SHALL increment by 1 on every response transfer and wrap from 2^CNT_W-1 to 0.
REQ-032 busy SHALL equal s1_valid | rsp_valid.
REQ-033 Request payloads SHALL be sampled only on the transfer edge, so changes to req_x or req_y while a request is not accepted SHALL have no effect.

Reset
REQ-034 While rst is high, regardless of clk, the following SHALL hold: req_ready=0, rsp_valid=0, rsp_z=0, rsp_id=0, mul_x=0, mul_y=0, busy=0, op_count=0, ptr=0, s1_valid=0.
REQ-035 Asserting rst mid-operation SHALL discard in-flight S1 and S2 entries, and no response for them SHALL appear after release.
REQ-036 On the first edge after rst deasserts, requester 0 SHALL have the highest priority.

Verification (the bench models mul_z = mul_x*mul_y exactly)
REQ-037 Drive only req_valid=4'b0100 with x=0x0F, y=0x03 at edge E and hold rsp_ready=1 -> after E+1, rsp_valid=1, rsp_z=0x002D, rsp_id=2, and op_count=1 after the next edge.
REQ-038 Drive req_valid=4'b1111 continuously with rsp_ready=1 from reset -> the grant order is 0,1,2,3,0,..., there is one response per cycle, and the ids arrive in the same order.
REQ-039 Hold rsp_ready=0 with requests pending -> exactly 2 transfers occur, then req_ready=0; rsp_z and rsp_id stay stable; after rsp_ready=1, the results drain in order with none lost or duplicated.
REQ-040 Drive x=0xFF, y=0xFF -> rsp_z=0xFE01; preset op_count to 0xFFFF via 65535 operations, then complete one more -> op_count=0x0000.
REQ-041 Assert rst while S1 and S2 are full -> all outputs are 0 immediately, no stale rsp_valid appears after release, and the next grant goes to requester 0.
